booth_multiplier_radix4: RTL and testbench

Sequential radix-4 (modified Booth) multiplier, parametrised in operand width, with run-time signed/unsigned mode.
- Retires two multiplier bits per cycle.
- Uses a start/busy/done handshake.
- Holds the product on the output until the next operation.
- Next-generation arithmetic unit for the lab datapath.
- Replaces fixed 4-bit radix-2 Booth designs.

---
 rtl/booth_multiplier_radix4.sv | 141 ++++++++++++++
 tb/tb_booth_multiplier_radix4.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_radix4.sv
// Sequential radix-4 (modified Booth) multiplier, signed/unsigned selectable at start.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand skips straight to DONE with p=0.
module booth_multiplier_radix4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int EW    = WIDTH + 2;
    localparam int AW    = WIDTH + 3;
    localparam int STEPS = WIDTH / 2 + 1;
    localparam int CW    = $clog2(STEPS + 1);

    generate
        if (WIDTH < 4 || (WIDTH % 2) != 0) begin : gWidthCheck
            $error("booth_multiplier_radix4: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [EW-1:0]      r_mcand;
    logic [AW-1:0]      r_acc;
    logic [EW:0]        r_mult;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_p;

    logic [EW-1:0]      w_aExt;
    logic [EW-1:0]      w_bExt;
    logic [AW-1:0]      w_mPos;
    logic [AW-1:0]      w_m2Pos;
    logic [AW-1:0]      w_addend;
    logic [AW-1:0]      w_sum;
    logic [AW-1:0]      w_accNext;
    logic [EW:0]        w_multNext;
    logic [2*WIDTH-1:0] w_product;
    logic               w_lastStep;
`ifdef BOOTH_ZERO_SKIP_EN
    logic               w_zeroOp;
    assign w_zeroOp = (a == '0) || (b == '0);
`endif

    assign w_aExt     = {{2{is_signed & a[WIDTH-1]}}, a};
    assign w_bExt     = {{2{is_signed & b[WIDTH-1]}}, b};
    assign w_mPos     = {r_mcand[EW-1], r_mcand};
    assign w_m2Pos    = {r_mcand, 1'b0};
    assign w_lastStep = (r_count == CW'(1));

    // Booth recoding of the three low multiplier bits into a signed partial product.
    always_comb begin
        w_addend = '0;
        case (r_mult[2:0])
            3'b001, 3'b010: w_addend = w_mPos;
            3'b011:         w_addend = w_m2Pos;
            3'b100:         w_addend = -w_m2Pos;
            3'b101, 3'b110: w_addend = -w_mPos;
            default:        w_addend = '0;
        endcase
    end

    assign w_sum      = r_acc + w_addend;
    assign w_accNext  = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    assign w_multNext = {w_sum[1:0], r_mult[EW:2]};
    assign w_product  = {w_accNext[WIDTH-3:0], w_multNext[EW:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef BOOTH_ZERO_SKIP_EN
                    w_nextState = w_zeroOp ? DONE : CALC;
`else
                    w_nextState = CALC;
`endif
                end
            end
            CALC:    if (w_lastStep) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    // p is only written when a result retires, so it holds through IDLE and the next CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_mult  <= '0;
            r_count <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand <= w_aExt;
                        r_acc   <= '0;
                        r_mult  <= {w_bExt, 1'b0};
                        r_count <= CW'(STEPS);
`ifdef BOOTH_ZERO_SKIP_EN
                        if (w_zeroOp) r_p <= '0;
`endif
                    end
                end
                CALC: begin
                    r_acc   <= w_accNext;
                    r_mult  <= w_multNext;
                    r_count <= r_count - CW'(1);
                    if (w_lastStep) r_p <= w_product;
                end
                default: ;
            endcase
        end
    end

    assign p = r_p;

endmodule

// File: tb/tb_booth_multiplier_radix4.sv
// Directed and swept checks of booth_multiplier_radix4 at WIDTH=8 and WIDTH=16.
// Zero-operand latency expectations follow BOOTH_ZERO_SKIP_EN.
module tb_booth_multiplier_radix4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, sgn8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] p8;
    logic        start16, sgn16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] p16;

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    booth_multiplier_radix4 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
    );

    booth_multiplier_radix4 #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sgn16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Launch one 8-bit operation, scramble the inputs after the start edge, and
    // optionally re-assert start at cycle disturbAt while the unit is busy.
    task automatic applyStimulus(input logic sgn, input logic [7:0] aa, input logic [7:0] bb,
                                 input int disturbAt, output int doneAt,
                                 output int busyCycles, output int donePulses);
        doneAt = 0;
        busyCycles = 0;
        donePulses = 0;
        @(negedge clk);
        start8 = 1'b1;
        sgn8 = sgn;
        a8 = aa;
        b8 = bb;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start8 = 1'b0;
                a8 = ~aa;
                b8 = ~bb;
                sgn8 = ~sgn;
            end
            if (k == disturbAt) begin
                start8 = 1'b1;
                a8 = 8'd9;
                b8 = 8'd9;
            end
            if (k == disturbAt + 1) start8 = 1'b0;
            if (busy8) busyCycles++;
            if (done8) begin
                donePulses++;
                if (doneAt == 0) doneAt = k;
            end
        end
    endtask

    task automatic runWide(input logic sgn, input logic [15:0] aa, input logic [15:0] bb,
                           output int doneAt);
        doneAt = 0;
        @(negedge clk);
        start16 = 1'b1;
        sgn16 = sgn;
        a16 = aa;
        b16 = bb;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start16 = 1'b0;
            if (done16) begin
                doneAt = k;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneAt, busyCycles, donePulses;
        int sa, sb;
        logic [15:0] ra, rb;
        logic        rs;
        logic [31:0] expected;

        rst_n = 1'b0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
        #7;
        checkOutput("reset_p8", 32'(p8), 32'h0);
        checkOutput("reset_busy8", 32'(busy8), 32'h0);
        checkOutput("reset_done8", 32'(done8), 32'h0);
        checkOutput("reset_p16", p16, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] signed -7 * 13");
        applyStimulus(1'b1, 8'hF9, 8'd13, 0, doneAt, busyCycles, donePulses);
        checkOutput("m7x13_p", 32'(p8), 32'h0000FFA5);
        checkOutput("m7x13_latency", 32'(doneAt), 32'd6);
        checkOutput("m7x13_busy", 32'(busyCycles), 32'd6);
        checkOutput("m7x13_pulses", 32'(donePulses), 32'd1);

        $display("[TB] signed corner operands");
        applyStimulus(1'b1, 8'h80, 8'h80, 0, doneAt, busyCycles, donePulses);
        checkOutput("m128xm128_p", 32'(p8), 32'h00004000);
        applyStimulus(1'b1, 8'h80, 8'h7F, 0, doneAt, busyCycles, donePulses);
        checkOutput("m128x127_p", 32'(p8), 32'h0000C080);

        $display("[TB] all-ones operands in both modes");
        applyStimulus(1'b0, 8'hFF, 8'hFF, 0, doneAt, busyCycles, donePulses);
        checkOutput("uFFxFF_p", 32'(p8), 32'h0000FE01);
        applyStimulus(1'b1, 8'hFF, 8'hFF, 0, doneAt, busyCycles, donePulses);
        checkOutput("sFFxFF_p", 32'(p8), 32'h00000001);

        $display("[TB] start ignored while busy");
        applyStimulus(1'b1, 8'd3, 8'd5, 3, doneAt, busyCycles, donePulses);
        checkOutput("ignore_p", 32'(p8), 32'd15);
        checkOutput("ignore_pulses", 32'(donePulses), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("ignore_hold_p", 32'(p8), 32'd15);
        checkOutput("ignore_idle_busy", 32'(busy8), 32'd0);

        $display("[TB] asynchronous reset mid-calculation");
        applyStimulus(1'b1, 8'd3, 8'd5, 0, doneAt, busyCycles, donePulses);
        checkOutput("prereset_p", 32'(p8), 32'd15);
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        checkOutput("prereset_busy", 32'(busy8), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_p", 32'(p8), 32'h0);
        checkOutput("midreset_busy", 32'(busy8), 32'd0);
        checkOutput("midreset_done", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'hFE, 8'hFD, 0, doneAt, busyCycles, donePulses);
        checkOutput("m2xm3_p", 32'(p8), 32'd6);

        $display("[TB] zero multiplicand");
        applyStimulus(1'b1, 8'd0, 8'd100, 0, doneAt, busyCycles, donePulses);
        checkOutput("zero_p", 32'(p8), 32'h0);
        checkOutput("zero_pulses", 32'(donePulses), 32'd1);
`ifdef BOOTH_ZERO_SKIP_EN
        checkOutput("zero_latency", 32'(doneAt), 32'd1);
        checkOutput("zero_busy", 32'(busyCycles), 32'd1);
`else
        checkOutput("zero_latency", 32'(doneAt), 32'd6);
        checkOutput("zero_busy", 32'(busyCycles), 32'd6);
`endif

        $display("[TB] WIDTH=16 sweep");
        for (int i = 0; i < 1000; i++) begin
            rs = (i % 2) == 1;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 1) begin ra = 16'h8000; rb = 16'h8000; end
            if (i == 2) begin ra = 16'hFFFF; rb = 16'hFFFF; end
            if (i == 3) begin ra = 16'h8000; rb = 16'h7FFF; end
            if (ra == 16'h0) ra = 16'h1;
            if (rb == 16'h0) rb = 16'h1;
            sa = $signed(ra);
            sb = $signed(rb);
            expected = rs ? 32'(sa * sb) : ({16'h0, ra} * {16'h0, rb});
            runWide(rs, ra, rb, doneAt);
            checkOutput($sformatf("w16_p_%0d", i), p16, expected);
            checkOutput($sformatf("w16_latency_%0d", i), 32'(doneAt), 32'd10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
